// File: rtl/drm_freq_probe_master.sv
// AXI4-Lite probe master: checks the DRM version word, clears the frequency counter, waits, then reads it back.
// Optional per-phase handshake watchdog enabled by defining DRM_FREQ_PROBE_TIMEOUT_EN.
module drm_freq_probe_master #(
   parameter int unsigned WAIT_CYCLES    = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        s_axi_aclk,
   input  logic        s_axi_arstn,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [31:0] result,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [15:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   input  logic [1:0]  m_axi_bresp,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [15:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp
);

   localparam logic [15:0] VER_ADDR  = 16'hFFF8;
   localparam logic [15:0] CNT_ADDR  = 16'hFFFC;
   localparam logic [31:0] VERSION   = 32'h60DC0DE0;
   localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_VER, S_WR_CLR, S_WAIT, S_RD_CNT, S_FIN
   } state_t;

   state_t      state_reg;
   logic [15:0] wait_cnt_reg;
   logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic        tmo;
   logic        fin_req;
   logic [1:0]  fin_code;

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wdata  = 32'd0;
   assign m_axi_wstrb  = 4'hF;

   assign ar_hs = m_axi_arvalid & m_axi_arready;
   assign r_hs  = m_axi_rready  & m_axi_rvalid;
   assign aw_hs = m_axi_awvalid & m_axi_awready;
   assign w_hs  = m_axi_wvalid  & m_axi_wready;
   assign b_hs  = m_axi_bready  & m_axi_bvalid;

`ifdef DRM_FREQ_PROBE_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wdog_reg;
   logic        in_phase;
   logic        any_hs;
   logic        wdog_expired;

   assign in_phase     = (state_reg == S_RD_VER) || (state_reg == S_WR_CLR) || (state_reg == S_RD_CNT);
   assign any_hs       = ar_hs | r_hs | aw_hs | w_hs | b_hs;
   assign wdog_expired = (wdog_reg == TMO_LAST);
   assign tmo          = in_phase & ~any_hs & wdog_expired;

   // Every handshake starts the next phase, so it also restarts the watchdog.
   always_ff @(posedge s_axi_aclk or negedge s_axi_arstn) begin
      if (!s_axi_arstn) begin
         wdog_reg <= '0;
      end else if (!in_phase || any_hs) begin
         wdog_reg <= '0;
      end else if (!wdog_expired) begin
         wdog_reg <= wdog_reg + 16'd1;
      end
   end
`else
   logic unused_timeout;

   assign tmo            = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   // A bad response outranks a version mismatch when both show up on the same beat.
   always_comb begin
      fin_req  = 1'b0;
      fin_code = 2'd0;
      case (state_reg)
         S_RD_VER: begin
            if (r_hs && ((m_axi_rresp != 2'b00) || (m_axi_rdata != VERSION))) begin
               fin_req  = 1'b1;
               fin_code = (m_axi_rresp != 2'b00) ? 2'd2 : 2'd1;
            end
         end
         S_WR_CLR: begin
            if (b_hs && (m_axi_bresp != 2'b00)) begin
               fin_req  = 1'b1;
               fin_code = 2'd2;
            end
         end
         S_RD_CNT: begin
            if (r_hs) begin
               fin_req  = 1'b1;
               fin_code = (m_axi_rresp != 2'b00) ? 2'd2 : 2'd0;
            end
         end
         default: ;
      endcase
      if (tmo) begin
         fin_req  = 1'b1;
         fin_code = 2'd3;
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_arstn) begin
      if (!s_axi_arstn) begin
         state_reg     <= S_IDLE;
         wait_cnt_reg  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_code      <= 2'd0;
         result        <= 32'd0;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr  <= 16'd0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= 16'd0;
         m_axi_rready  <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  busy          <= 1'b1;
                  m_axi_arvalid <= 1'b1;
                  m_axi_araddr  <= VER_ADDR;
                  state_reg     <= S_RD_VER;
               end
            end
            S_RD_VER, S_RD_CNT: begin
               if (ar_hs) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
               end
               if (r_hs) begin
                  m_axi_rready <= 1'b0;
                  if (state_reg == S_RD_CNT) begin
                     result <= m_axi_rdata;
                  end else begin
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     m_axi_awaddr  <= VER_ADDR;
                     state_reg     <= S_WR_CLR;
                  end
               end
            end
            S_WR_CLR: begin
               if (aw_hs) m_axi_awvalid <= 1'b0;
               if (w_hs)  m_axi_wvalid  <= 1'b0;
               // Response is accepted only once both address and data have been taken.
               if (!m_axi_bready && (aw_hs || !m_axi_awvalid) && (w_hs || !m_axi_wvalid)) begin
                  m_axi_bready <= 1'b1;
               end
               if (b_hs) begin
                  m_axi_bready <= 1'b0;
                  wait_cnt_reg <= '0;
                  state_reg    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt_reg == WAIT_LAST) begin
                  m_axi_arvalid <= 1'b1;
                  m_axi_araddr  <= CNT_ADDR;
                  state_reg     <= S_RD_CNT;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 16'd1;
               end
            end
            S_FIN: begin
               done      <= 1'b0;
               error     <= 1'b0;
               busy      <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase

         if (fin_req) begin
            state_reg     <= S_FIN;
            done          <= 1'b1;
            error         <= (fin_code != 2'd0);
            err_code      <= fin_code;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_drm_freq_probe_master.sv
// Bench for drm_freq_probe_master: AXI4-Lite slave with version/counter registers and per-probe checks.
module tb_drm_freq_probe_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [31:0] result;
   logic        m_axi_awvalid, m_axi_awready;
   logic [15:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_wvalid, m_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid, m_axi_bready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_arvalid, m_axi_arready;
   logic [15:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_rvalid, m_axi_rready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;

   always #5 clk = ~clk;

   drm_freq_probe_master #(
      .WAIT_CYCLES    (10),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_arstn   (rst_n),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .err_code      (err_code),
      .result        (result),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp)
   );

   // Slave model: version word at FFF8 (write clears the counter), free-running counter at FFFC.
   logic [31:0] sl_version = 32'h60DC0DE0;
   logic [1:0]  sl_rresp = 2'b00;
   logic [1:0]  sl_bresp = 2'b00;
   int          sl_aw_dly = 0;
   int          sl_w_dly = 0;
   logic        sl_ar_stuck = 1'b0;

   int          aw_wait, w_wait;
   logic        aw_got, w_got, bvalid_q, rvalid_q;
   logic [15:0] wr_addr_q, rd_addr_q;
   logic [31:0] cnt_model;

   assign m_axi_arready = m_axi_arvalid && !sl_ar_stuck;
   assign m_axi_awready = m_axi_awvalid && (aw_wait >= sl_aw_dly);
   assign m_axi_wready  = m_axi_wvalid && (w_wait >= sl_w_dly);
   assign m_axi_rvalid  = rvalid_q;
   assign m_axi_rdata   = (rd_addr_q == 16'hFFFC) ? cnt_model : sl_version;
   assign m_axi_rresp   = sl_rresp;
   assign m_axi_bvalid  = bvalid_q;
   assign m_axi_bresp   = sl_bresp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
         bvalid_q <= 1'b0; rvalid_q <= 1'b0; wr_addr_q <= 16'd0; rd_addr_q <= 16'd0;
         cnt_model <= 32'd0;
      end else begin
         cnt_model <= cnt_model + 32'd1;
         if (m_axi_bvalid && m_axi_bready) begin
            bvalid_q <= 1'b0;
            if (wr_addr_q == 16'hFFF8) cnt_model <= 32'd0;
         end
         aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
         w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
         if (m_axi_awvalid && m_axi_awready) begin
            aw_got <= 1'b1;
            wr_addr_q <= m_axi_awaddr;
         end
         if (m_axi_wvalid && m_axi_wready) w_got <= 1'b1;
         if ((aw_got || (m_axi_awvalid && m_axi_awready)) &&
             (w_got || (m_axi_wvalid && m_axi_wready)) && !bvalid_q) begin
            bvalid_q <= 1'b1;
            aw_got <= 1'b0;
            w_got <= 1'b0;
         end
         if (m_axi_arvalid && m_axi_arready) begin
            rvalid_q <= 1'b1;
            rd_addr_q <= m_axi_araddr;
         end
         if (m_axi_rvalid && m_axi_rready) rvalid_q <= 1'b0;
      end
   end

   // Bus monitors; never reset, compared as deltas.
   int aw_hs_cnt = 0, cnt_rd_cnt = 0, aw_hi_cnt = 0, w_hi_cnt = 0;
   int viol_cnt = 0, done_cnt = 0, b_hs_cnt = 0;

   always @(posedge clk) begin
      if (m_axi_awvalid && m_axi_awready) aw_hs_cnt <= aw_hs_cnt + 1;
      if (m_axi_arvalid && m_axi_arready && m_axi_araddr == 16'hFFFC) cnt_rd_cnt <= cnt_rd_cnt + 1;
      if (m_axi_awvalid) aw_hi_cnt <= aw_hi_cnt + 1;
      if (m_axi_wvalid) w_hi_cnt <= w_hi_cnt + 1;
      if (m_axi_bvalid && m_axi_bready) b_hs_cnt <= b_hs_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if ((m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) ||
          (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid)) ||
          (m_axi_rready && m_axi_arvalid)) viol_cnt <= viol_cnt + 1;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns what was on the outputs during the done cycle.
   task automatic run_probe(input string tag, output logic got_done, output logic got_err,
                            output logic [1:0] got_code, output logic [31:0] got_res);
      got_done = 1'b0; got_err = 1'b0; got_code = 2'd0; got_res = 32'd0;
      check({tag, "_busy_pre"}, busy, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_rise"}, busy, 1'b1);
      for (int i = 0; i < 300; i++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_done_seen"}, got_done, 1'b1);
      got_err = error; got_code = err_code; got_res = result;
      @(negedge clk);
      check({tag, "_pulse_end"}, {busy, done}, 2'b00);
      check({tag, "_code_hold"}, err_code, got_code);
   endtask

   typedef struct {
      logic [31:0] version;
      logic [1:0]  rresp;
      logic [1:0]  bresp;
      int          aw_dly;
      int          w_dly;
      logic [1:0]  exp_code;
      logic [31:0] exp_result;
      int          exp_aw_hs;
      int          exp_cnt_rd;
      int          exp_aw_hi;
      int          exp_w_hi;
   } vec_t;

   vec_t        vecs [6];
   logic        g_done, g_err;
   logic [1:0]  g_code;
   logic [31:0] g_res;
   int          s_aw_hs, s_cnt_rd, s_aw_hi, s_w_hi, s_viol, s_done, s_bhs;
   int          busy_hi, k;

   initial begin
      // Counter reads 11: 10 WAIT cycles plus the AR cycle before rdata is sampled.
      vecs[0] = '{32'h60DC0DE0, 2'd0, 2'd0, 0, 0, 2'd0, 32'd11, 1, 1, 1, 1};
      vecs[1] = '{32'h12345678, 2'd0, 2'd0, 0, 0, 2'd1, 32'd11, 0, 0, 0, 0};
      vecs[2] = '{32'h60DC0DE0, 2'd0, 2'd2, 0, 0, 2'd2, 32'd11, 1, 0, 1, 1};
      vecs[3] = '{32'h60DC0DE0, 2'd0, 2'd0, 5, 0, 2'd0, 32'd11, 1, 1, 6, 1};
      vecs[4] = '{32'h60DC0DE0, 2'd0, 2'd0, 0, 3, 2'd0, 32'd11, 1, 1, 1, 4};
      vecs[5] = '{32'h12345678, 2'd2, 2'd0, 0, 0, 2'd2, 32'd11, 0, 0, 0, 0};

      start = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", {busy, done, error, err_code}, 5'd0);
      check("rst_result", result, 32'd0);
      check("rst_valids", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 5'd0);
      check("rst_addrs", {m_axi_araddr, m_axi_awaddr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         sl_version = vecs[i].version; sl_rresp = vecs[i].rresp; sl_bresp = vecs[i].bresp;
         sl_aw_dly = vecs[i].aw_dly; sl_w_dly = vecs[i].w_dly;
         @(negedge clk);
         s_aw_hs = aw_hs_cnt; s_cnt_rd = cnt_rd_cnt; s_aw_hi = aw_hi_cnt; s_w_hi = w_hi_cnt; s_viol = viol_cnt;
         run_probe($sformatf("v%0d", i), g_done, g_err, g_code, g_res);
         repeat (3) @(negedge clk);
         $display("vec %0d: error=%0d err_code=%0d result=%0d", i, g_err, g_code, g_res);
         check($sformatf("v%0d_code", i), g_code, vecs[i].exp_code);
         check($sformatf("v%0d_error", i), g_err, (vecs[i].exp_code != 2'd0));
         check($sformatf("v%0d_result", i), g_res, vecs[i].exp_result);
         check($sformatf("v%0d_aw_hs", i), aw_hs_cnt - s_aw_hs, vecs[i].exp_aw_hs);
         check($sformatf("v%0d_cnt_reads", i), cnt_rd_cnt - s_cnt_rd, vecs[i].exp_cnt_rd);
         check($sformatf("v%0d_aw_hi", i), aw_hi_cnt - s_aw_hi, vecs[i].exp_aw_hi);
         check($sformatf("v%0d_w_hi", i), w_hi_cnt - s_w_hi, vecs[i].exp_w_hi);
         check($sformatf("v%0d_bus_rules", i), viol_cnt - s_viol, 0);
      end
      check("const_wdata_wstrb", {m_axi_wdata, m_axi_wstrb}, 36'h0_0000_000F);
      sl_version = 32'h60DC0DE0; sl_rresp = 2'b00; sl_bresp = 2'b00; sl_aw_dly = 0; sl_w_dly = 0;

      // A second start while busy must neither restart nor queue a probe.
      s_done = done_cnt; s_cnt_rd = cnt_rd_cnt;
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("ign_busy_mid", busy, 1'b1);
      start = 1'b1; @(negedge clk); start = 1'b0;
      g_done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (done) begin g_done = 1'b1; break; end
         @(negedge clk);
      end
      check("ign_done_seen", g_done, 1'b1);
      check("ign_result", result, 32'd11);
      busy_hi = 0;
      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         if (busy) busy_hi++;
         @(negedge clk);
      end
      $display("start-while-busy: done pulses=%0d counter reads=%0d", done_cnt - s_done, cnt_rd_cnt - s_cnt_rd);
      check("ign_busy_after", busy_hi, 0);
      check("ign_done_count", done_cnt - s_done, 1);
      check("ign_cnt_reads", cnt_rd_cnt - s_cnt_rd, 1);

`ifdef DRM_FREQ_PROBE_TIMEOUT_EN
      sl_ar_stuck = 1'b1;
      start = 1'b1; @(negedge clk); start = 1'b0;
      check("tmo_arvalid_up", m_axi_arvalid, 1'b1);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin k = i; break; end
      end
      $display("timeout: done after %0d cycles err_code=%0d", k, err_code);
      check("tmo_done_delay", k, 8);
      check("tmo_code", {error, err_code}, 3'b111);
      check("tmo_arvalid_drop", m_axi_arvalid, 1'b0);
      sl_ar_stuck = 1'b0;
      repeat (3) @(negedge clk);
`endif

      // Reset while counting in WAIT: everything returns to reset values with no done pulse.
      s_bhs = b_hs_cnt;
      start = 1'b1; @(negedge clk); start = 1'b0;
      g_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (b_hs_cnt != s_bhs) begin g_done = 1'b1; break; end
         @(negedge clk);
      end
      check("rstmid_b_seen", g_done, 1'b1);
      repeat (3) @(negedge clk);
      s_done = done_cnt;
      rst_n = 1'b0;
      #1;
      check("rstmid_state", {busy, done, error, err_code}, 5'd0);
      check("rstmid_result", result, 32'd0);
      check("rstmid_valids", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 5'd0);
      check("rstmid_addrs", {m_axi_araddr, m_axi_awaddr}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      $display("reset in WAIT: done pulses afterwards=%0d busy=%0d", done_cnt - s_done, busy);
      check("rstmid_no_done", done_cnt - s_done, 0);
      check("rstmid_idle", busy, 1'b0);
      run_probe("fresh", g_done, g_err, g_code, g_res);
      $display("fresh probe: error=%0d err_code=%0d result=%0d", g_err, g_code, g_res);
      check("fresh_code", {g_err, g_code}, 3'b000);
      check("fresh_result", g_res, 32'd11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
